// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: NONSEQ/SEQ address pipelining, WRAP/INCR address generation,
// read beat return and write data pull. Define AHB_ERR_ABORT_EN for ERROR-response abort.
module ahb_burst_master #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [2:0]        req_burst,
   input  logic              req_write,
   input  logic [LEN_W-1:0]  req_len,
   output logic [ADDR_W-1:0] haddr,
   output logic [1:0]        htrans,
   output logic              hwrite,
   output logic [2:0]        hburst,
   output logic [2:0]        hsize,
   output logic [DATA_W-1:0] hwdata,
   input  logic [DATA_W-1:0] hrdata,
   input  logic              hready,
   input  logic              hresp,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_pop,
   output logic              rd_valid,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_last,
`ifdef AHB_ERR_ABORT_EN
   output logic              err_abort,
`endif
   output logic              busy
);

   localparam int BYTES   = DATA_W / 8;
   localparam int HSIZE_V = $clog2(BYTES);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_BURST, S_LAST} state_t;

   state_t            state, state_nxt;
   logic [2:0]        burst_q;
   logic              write_q;
   logic [LEN_W:0]    beats_q;
   logic [LEN_W:0]    acnt;
   logic              nseq_q;
   logic              dp_vld, dp_write, dp_last;
   logic [ADDR_W-1:0] dp_addr;
   logic              addr_acc, last_addr, err_start, rd_fire, err_q;
   logic              is_wrap, cross_1k;
   logic [ADDR_W-1:0] incr_addr, wrap_mask, next_addr;

   function automatic logic [LEN_W:0] burst_beats(input logic [2:0] b, input logic [LEN_W-1:0] len);
      case (b)
         3'b000:        burst_beats = (LEN_W+1)'(1);
         3'b001:        burst_beats = {1'b0, len} + (LEN_W+1)'(1);
         3'b010, 3'b011: burst_beats = (LEN_W+1)'(4);
         3'b100, 3'b101: burst_beats = (LEN_W+1)'(8);
         default:       burst_beats = (LEN_W+1)'(16);
      endcase
   endfunction

   assign addr_acc  = ((state == S_ADDR) || (state == S_BURST)) && hready;
   assign last_addr = ((acnt + (LEN_W+1)'(1)) == beats_q);

   // WRAP window is beats*BYTES; beats is 4/8/16 encoded in hburst[2:1]
   assign is_wrap   = !burst_q[0] && (burst_q != 3'b000);
   assign wrap_mask = (ADDR_W'(1) << (32'(burst_q[2:1]) + 32'd1 + HSIZE_V)) - ADDR_W'(1);
   assign incr_addr = haddr + ADDR_W'(BYTES);
   assign next_addr = is_wrap ? ((haddr & ~wrap_mask) | (incr_addr & wrap_mask)) : incr_addr;
   assign cross_1k  = !is_wrap && (incr_addr[9:0] == 10'd0);

`ifdef AHB_ERR_ABORT_EN
   assign err_start = dp_vld && hresp && !hready;
`else
   logic unused_hresp;
   assign unused_hresp = hresp;
   assign err_start    = 1'b0;
`endif

   assign rd_fire   = dp_vld && hready && !dp_write && !err_q;

   always_ff @(posedge clk) begin
      if (!rstn) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      htrans    = 2'b00;
      case (state)
         S_IDLE:  if (req_valid) state_nxt = S_ADDR;
         S_ADDR, S_BURST: begin
            htrans = (state == S_ADDR || nseq_q) ? 2'b10 : 2'b11;
            if (err_start)     state_nxt = S_LAST;
            else if (addr_acc) state_nxt = last_addr ? S_LAST : S_BURST;
         end
         S_LAST:  if (hready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign req_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign hburst    = busy ? burst_q : 3'b000;
   assign hwrite    = busy && write_q;
   assign hsize     = 3'(HSIZE_V);
   assign hwdata    = (dp_vld && dp_write) ? wr_data : '0;
   assign wr_pop    = dp_vld && dp_write && hready;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         haddr    <= '0;
         burst_q  <= 3'b000;
         write_q  <= 1'b0;
         beats_q  <= '0;
         acnt     <= '0;
         nseq_q   <= 1'b0;
         dp_vld   <= 1'b0;
         dp_write <= 1'b0;
         dp_last  <= 1'b0;
         dp_addr  <= '0;
         rd_valid <= 1'b0;
         rd_addr  <= '0;
         rd_data  <= '0;
         rd_last  <= 1'b0;
      end else begin
         if (state == S_IDLE && req_valid) begin
            haddr   <= req_addr;
            burst_q <= req_burst;
            write_q <= req_write;
            beats_q <= burst_beats(req_burst, req_len);
            acnt    <= '0;
            nseq_q  <= 1'b0;
         end
         if (addr_acc) begin
            acnt   <= acnt + (LEN_W+1)'(1);
            nseq_q <= cross_1k;
            if (!last_addr) haddr <= next_addr;
         end
         // data phase trails its address phase by one accepted cycle
         if (hready) begin
            dp_vld <= addr_acc;
            if (addr_acc) begin
               dp_addr  <= haddr;
               dp_write <= write_q;
               dp_last  <= last_addr;
            end
         end
         rd_valid <= rd_fire;
         rd_last  <= rd_fire && dp_last;
         if (rd_fire) begin
            rd_addr <= dp_addr;
            rd_data <= hrdata;
         end
      end
   end

`ifdef AHB_ERR_ABORT_EN
   always_ff @(posedge clk) begin
      if (!rstn) begin
         err_q     <= 1'b0;
         err_abort <= 1'b0;
      end else begin
         err_abort <= err_q && dp_vld && hready;
         if (state_nxt == S_IDLE) err_q <= 1'b0;
         else if (err_start)      err_q <= 1'b1;
      end
   end
`else
   assign err_q = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_burst_master.sv
// Randomized bench for ahb_burst_master: bus-level reference model plus directed literal checks.
module tb_ahb_burst_master;
   localparam int AW = 32, DW = 32, LW = 8;

   logic          clk = 1'b0, rstn = 1'b0;
   logic          req_valid = 1'b0, req_ready, req_write = 1'b0;
   logic [AW-1:0] req_addr = '0, haddr, rd_addr;
   logic [2:0]    req_burst = '0, hburst, hsize;
   logic [LW-1:0] req_len = '0;
   logic [1:0]    htrans;
   logic          hwrite, hready = 1'b1, hresp = 1'b0;
   logic [DW-1:0] hwdata, hrdata, wr_data = '0, rd_data;
   logic          wr_pop, rd_valid, rd_last, busy;
`ifdef AHB_ERR_ABORT_EN
   logic          err_abort;
`endif

   always #5 clk = ~clk;

   ahb_burst_master #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_burst(req_burst), .req_write(req_write), .req_len(req_len),
      .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hburst(hburst), .hsize(hsize),
      .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp),
      .wr_data(wr_data), .wr_pop(wr_pop), .rd_valid(rd_valid), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_last(rd_last),
`ifdef AHB_ERR_ABORT_EN
      .err_abort(err_abort),
`endif
      .busy(busy));

   int chk = 0, errs = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      chk++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic fail(input string name);
      chk++; errs++;
      $display("FAIL %s", name);
   endtask

   function automatic logic [31:0] data_of(input logic [31:0] a);
      if (a == 32'h100) return 32'hDEADBEEF;
      return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
   endfunction

   // reference expectations
   logic [31:0] exp_a[$], exp_t[$], exp_ra[$], exp_rd[$], exp_rl[$], wq[$];
   logic [31:0] obs_a[$], obs_t[$], obs_ra[$], obs_rd[$], obs_rl[$], obs_w[$];
   logic        cur_write = 1'b0;
   logic [2:0]  cur_burst = '0;
   int          hr_mode = 0;

   // slave + monitor in one process: sample at negedge, act at posedge+1
   logic [31:0] sl_addr = '0;
   assign hrdata = hready ? data_of(sl_addr) : 32'hBAD0BAD0;

   initial begin : mon
      logic        prev_stall, acc_pend, pop_pend;
      logic [31:0] prev_a, prev_t, acc_addr;
      int          cyc;
      prev_stall = 0; acc_pend = 0; pop_pend = 0; prev_a = 0; prev_t = 0; acc_addr = 0; cyc = 0;
      forever begin
         @(negedge clk);
         if (rstn) begin
            if (prev_stall) begin
               check("haddr_hold", haddr, prev_a);
               check("htrans_hold", 32'(htrans), prev_t);
            end
            prev_stall = (htrans != 2'b00) && !hready;
            prev_a = haddr; prev_t = 32'(htrans);
            if (htrans != 2'b00 && hready) begin
               if (exp_a.size() == 0) fail("addr_unexpected");
               else begin
                  check("haddr", haddr, exp_a.pop_front());
                  check("htrans", 32'(htrans), exp_t.pop_front());
                  check("hwrite", 32'(hwrite), 32'(cur_write));
                  check("hburst", 32'(hburst), 32'(cur_burst));
                  check("hsize", 32'(hsize), 32'd2);
                  check("busy", 32'(busy), 32'd1);
               end
               obs_a.push_back(haddr); obs_t.push_back(32'(htrans));
               acc_pend = 1; acc_addr = haddr;
            end
            if (wr_pop) begin
               if (wq.size() == 0) fail("wr_pop_unexpected");
               else check("hwdata", hwdata, wq[0]);
               obs_w.push_back(hwdata);
               pop_pend = 1;
            end
            if (rd_valid) begin
               if (exp_ra.size() == 0) fail("rd_unexpected");
               else begin
                  check("rd_addr", rd_addr, exp_ra.pop_front());
                  check("rd_data", rd_data, exp_rd.pop_front());
                  check("rd_last", 32'(rd_last), exp_rl.pop_front());
               end
               obs_ra.push_back(rd_addr); obs_rd.push_back(rd_data); obs_rl.push_back(32'(rd_last));
            end
         end else begin
            prev_stall = 0; acc_pend = 0; pop_pend = 0;
         end
         @(posedge clk); #1;
         if (acc_pend) sl_addr = acc_addr;
         acc_pend = 0;
         if (pop_pend && wq.size() > 0) void'(wq.pop_front());
         pop_pend = 0;
         wr_data = (wq.size() > 0) ? wq[0] : 32'h0;
         cyc++;
         case (hr_mode)
            1:       hready = ($urandom_range(0, 2) != 0);
            2:       hready = ((cyc / 2) % 2) == 0;
            default: hready = 1'b1;
         endcase
      end
   end

   task automatic clear_all();
      exp_a.delete(); exp_t.delete(); exp_ra.delete(); exp_rd.delete(); exp_rl.delete(); wq.delete();
      obs_a.delete(); obs_t.delete(); obs_ra.delete(); obs_rd.delete(); obs_rl.delete(); obs_w.delete();
   endtask

   // builds the expected beat list from the burst rules, then hands the request over
   task automatic start_burst(input logic [31:0] addr, input logic [2:0] burst, input logic wr,
                              input logic [7:0] len, input bit lit_wdata);
      int beats, win;
      logic [31:0] a, base;
      clear_all();
      case (burst)
         3'd0: beats = 1;
         3'd1: beats = int'(len) + 1;
         3'd2, 3'd3: beats = 4;
         3'd4, 3'd5: beats = 8;
         default: beats = 16;
      endcase
      win = beats * 4;
      a = addr;
      for (int i = 0; i < beats; i++) begin
         exp_a.push_back(a);
         exp_t.push_back((i == 0 || (burst[0] && (a % 1024) == 0)) ? 32'd2 : 32'd3);
         if (wr) wq.push_back(lit_wdata ? 32'h1111 * (i + 1) : $urandom);
         else begin
            exp_ra.push_back(a); exp_rd.push_back(data_of(a)); exp_rl.push_back(32'(i == beats - 1));
         end
         if (burst != 3'd0 && !burst[0]) begin
            base = a - (a % win);
            a = base + ((a - base + 4) % win);
         end else a = a + 4;
      end
      cur_write = wr; cur_burst = burst;
      @(posedge clk); #1;
      req_valid = 1'b1; req_addr = addr; req_burst = burst; req_write = wr; req_len = len;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      int n;
      n = 1;
      @(negedge clk);
      while (!req_ready && n < 3000) begin
         @(negedge clk); n++;
      end
      if (!req_ready) fail("burst_timeout");
      lat = n;
      @(negedge clk);
      check("addr_left", exp_a.size(), 0);
      check("rd_left", exp_ra.size(), 0);
      check("wr_left", wq.size(), 0);
   endtask

   initial begin
      int lat, guard;
      logic [2:0] b;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_htrans", 32'(htrans), 0);
      check("rst_haddr", haddr, 0);
      check("rst_hwrite", 32'(hwrite), 0);
      check("rst_hburst", 32'(hburst), 0);
      check("rst_hwdata", hwdata, 0);
      check("rst_rd", {rd_valid, rd_last, wr_pop, busy}, 0);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_req_ready", 32'(req_ready), 1);
      @(posedge clk); #1 rstn = 1'b1;

      // SINGLE read
      hr_mode = 0;
      start_burst(32'h100, 3'd0, 1'b0, 8'd0, 0);
      wait_done(lat);
      check("single_lat", lat, 3);
      check("single_n", obs_a.size(), 1);
      check("single_addr", obs_a[0], 32'h100);
      check("single_nonseq", obs_t[0], 32'd2);
      check("single_data", obs_rd[0], 32'hDEADBEEF);
      check("single_last", obs_rl[0], 1);

      // WRAP4 read from 0x38
      start_burst(32'h38, 3'd2, 1'b0, 8'd0, 0);
      wait_done(lat);
      check("wrap4_a1", obs_a[1], 32'h3C);
      check("wrap4_a2", obs_a[2], 32'h30);
      check("wrap4_a3", obs_a[3], 32'h34);
      check("wrap4_seq", obs_t[2], 32'd3);
      check("wrap4_last_addr", obs_ra[3], 32'h34);
      check("wrap4_last", obs_rl[3], 1);

      // INCR8 across 1KB with toggling hready
      hr_mode = 2;
      start_burst(32'h3F8, 3'd5, 1'b0, 8'd0, 0);
      wait_done(lat);
      check("incr8_a2", obs_a[2], 32'h400);
      check("incr8_1k_nonseq", obs_t[2], 32'd2);
      check("incr8_after_seq", obs_t[3], 32'd3);
      check("incr8_beats", obs_ra.size(), 8);

      // write INCR4
      hr_mode = 0;
      start_burst(32'h0, 3'd3, 1'b1, 8'd0, 1);
      wait_done(lat);
      check("wr_pops", obs_w.size(), 4);
      check("wr_d0", obs_w[0], 32'h1111);
      check("wr_d3", obs_w[3], 32'h4444);

      // reset during beat 3 of WRAP16
      start_burst(32'h80, 3'd6, 1'b0, 8'd0, 0);
      guard = 0;
      while (obs_a.size() < 3 && guard < 100) begin
         @(negedge clk); guard++;
      end
      if (obs_a.size() < 3) fail("wrap16_start_timeout");
      @(posedge clk); #1 rstn = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("mrst_htrans", 32'(htrans), 0);
      check("mrst_busy", 32'(busy), 0);
      check("mrst_ready", 32'(req_ready), 1);
      check("mrst_rd_valid", 32'(rd_valid), 0);
      clear_all();
      @(posedge clk); #1 rstn = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("post_rst_rd_valid", 32'(rd_valid), 0);
      end

      // max-length INCR, then random bursts
      hr_mode = 1;
      start_burst(32'h1F00, 3'd1, 1'b0, 8'hFF, 0);
      wait_done(lat);
      check("incr256_beats", obs_ra.size(), 256);
      for (int k = 0; k < 40; k++) begin
         hr_mode = $urandom_range(0, 2);
         b = 3'($urandom_range(0, 7));
         start_burst({18'd0, 12'($urandom_range(0, 4095)), 2'b00}, b, 1'($urandom_range(0, 1)),
                     8'($urandom_range(0, 20)), 0);
         wait_done(lat);
      end

      $display("Simulation finished: %0d checks, %0d errors", chk, errs);
      $finish;
   end
endmodule
